// File: rtl/sa_pkg.sv
// sa_pkg: shared sizing, result latency and state encoding for the systolic array sequencer
package sa_pkg;
  localparam int PE_SIZE = 2;
  localparam int MAX_ROWS = 256;
  localparam int ROW_W = $clog2(MAX_ROWS + 1);
  localparam int RESULT_LAT = 2 * PE_SIZE;
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;
endpackage

// File: rtl/sa_ctrl_delay.sv
// sa_ctrl_delay: DEPTH-stage shift register with sync clear; o_taps[k] is i_d delayed k+1 cycles
module sa_ctrl_delay #(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_d,
  output logic [DEPTH-1:0] o_taps
);
  logic [DEPTH-1:0] r_taps;
  always_ff @(posedge clk)
    r_taps <= i_clr ? '0 : {r_taps[DEPTH-2:0], i_d};
  assign o_taps = r_taps;
endmodule

// File: rtl/sa_ctrl.sv
// sa_ctrl: tile sequencer for the systolic array -- weight preload, ifmap stream, psum skew, result write-back
module sa_ctrl
  import sa_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [ROW_W-1:0]   num_rows_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               wbuf_rd_en_o,
  output logic [ROW_W-1:0]   wbuf_rd_addr_o,
  output logic               ibuf_rd_en_o,
  output logic [ROW_W-1:0]   ibuf_rd_addr_o,
  output logic [PE_SIZE-1:0] weight_en_col_o,
  output logic               ifmap_en_o,
  output logic [PE_SIZE-1:0] psum_en_row_o,
  output logic               obuf_wr_en_o,
  output logic [ROW_W-1:0]   obuf_wr_addr_o
);
  localparam logic [RESULT_LAT-1:0] LAST_ONLY = {1'b1, {(RESULT_LAT-1){1'b0}}};
  state_t r_state, w_next;
  logic [ROW_W-1:0] r_n, r_cnt, r_wr_cnt;
  logic r_wen, r_post_done;
  logic w_accept, w_last, w_drained;
  logic [PE_SIZE-1:0] w_skew;
  logic [RESULT_LAT-1:0] w_wr;
  // The cycle right after DONE never accepts, so a held start spaces operations by one idle cycle
  always_comb begin
    w_accept = r_state == IDLE && !r_post_done && start_i && num_rows_i != '0 && num_rows_i <= ROW_W'(MAX_ROWS);
    w_last = r_cnt == (r_state == LOAD_W ? ROW_W'(PE_SIZE - 1) : r_n - 1'b1);
    w_drained = w_wr == LAST_ONLY && r_wr_cnt == r_n - 1'b1;
    w_next = r_state == IDLE   ? (w_accept  ? LOAD_W : IDLE)   :
             r_state == LOAD_W ? (w_last    ? STREAM : LOAD_W) :
             r_state == STREAM ? (w_last    ? DRAIN  : STREAM) :
             r_state == DRAIN  ? (w_drained ? DONE   : DRAIN)  : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_n <= '0;
      r_cnt <= '0;
      r_wr_cnt <= '0;
      r_wen <= 1'b0;
      r_post_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wen <= r_state == LOAD_W;
      r_post_done <= r_state == DONE;
      r_cnt <= (w_next == r_state && (r_state == LOAD_W || r_state == STREAM)) ? r_cnt + 1'b1 : '0;
      if (w_accept) r_n <= num_rows_i;
      r_wr_cnt <= w_accept ? '0 : obuf_wr_en_o ? r_wr_cnt + 1'b1 : r_wr_cnt;
    end
  end
  // Fed from the ifmap read strobe, one cycle ahead of ifmap_en, so tap 0 is ifmap_en itself
  sa_ctrl_delay #(.DEPTH(PE_SIZE)) u_skew (
    .clk    (clk),
    .i_clr  (rst),
    .i_d    (ibuf_rd_en_o),
    .o_taps (w_skew)
  );
  sa_ctrl_delay #(.DEPTH(RESULT_LAT)) u_wr (
    .clk    (clk),
    .i_clr  (rst),
    .i_d    (ifmap_en_o),
    .o_taps (w_wr)
  );
  assign busy_o = r_state != IDLE;
  assign done_o = r_state == DONE;
  assign wbuf_rd_en_o = r_state == LOAD_W;
  assign wbuf_rd_addr_o = r_cnt;
  assign ibuf_rd_en_o = r_state == STREAM;
  assign ibuf_rd_addr_o = r_cnt;
  assign weight_en_col_o = {PE_SIZE{r_wen}};
  assign ifmap_en_o = w_skew[0];
  assign psum_en_row_o = w_skew;
  assign obuf_wr_en_o = w_wr[RESULT_LAT-1];
  assign obuf_wr_addr_o = r_wr_cnt;
endmodule

// File: tb/tb_sa_ctrl.sv
// tb_sa_ctrl: checks sa_ctrl against a cycle-offset timing model plus directed literal checks
module tb_sa_ctrl;
  localparam int P = 2;
  localparam int RL = 2 * P;
  localparam int RW = 9;
  logic clk = 0, rst = 1, start_i = 0;
  logic [RW-1:0] num_rows_i = '0;
  logic busy_o, done_o, wbuf_rd_en_o, ibuf_rd_en_o, ifmap_en_o, obuf_wr_en_o;
  logic [RW-1:0] wbuf_rd_addr_o, ibuf_rd_addr_o, obuf_wr_addr_o;
  logic [P-1:0] weight_en_col_o, psum_en_row_o;
  int cyc = 0, n_chk = 0, n_fail = 0;
  int m_s = 0, m_n = 0, m_last_done = -100;
  bit m_val = 0, m_post_rst = 0;
  int done_q[$], wr_q[$], wa_q[$];
  int last_ia = -1, s0;

  sa_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .num_rows_i(num_rows_i),
    .busy_o(busy_o), .done_o(done_o),
    .wbuf_rd_en_o(wbuf_rd_en_o), .wbuf_rd_addr_o(wbuf_rd_addr_o),
    .ibuf_rd_en_o(ibuf_rd_en_o), .ibuf_rd_addr_o(ibuf_rd_addr_o),
    .weight_en_col_o(weight_en_col_o), .ifmap_en_o(ifmap_en_o),
    .psum_en_row_o(psum_en_row_o), .obuf_wr_en_o(obuf_wr_en_o),
    .obuf_wr_addr_o(obuf_wr_addr_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: an accepted start in cycle s fixes every output as a window of offsets d = t - s
  always @(negedge clk) begin
    int d, dl, ep;
    bit ew, ei, eo;
    if (cyc >= 1) begin
      d = cyc - m_s;
      dl = P + m_n + 2 + RL;
      ew = m_val && d >= 1 && d <= P;
      ei = m_val && d >= P + 1 && d <= P + m_n;
      eo = m_val && d >= P + 2 + RL && d <= P + m_n + 1 + RL;
      ep = 0;
      for (int j = 0; j < P; j++)
        if (m_val && d >= P + 2 + j && d <= P + m_n + 1 + j) ep |= (1 << j);
      chk("busy", busy_o, m_val && d >= 1 && d <= dl);
      chk("done", done_o, m_val && d == dl);
      chk("wbuf_rd_en", wbuf_rd_en_o, ew);
      chk("weight_en", weight_en_col_o, (m_val && d >= 2 && d <= P + 1) ? (1 << P) - 1 : 0);
      chk("ibuf_rd_en", ibuf_rd_en_o, ei);
      chk("ifmap_en", ifmap_en_o, m_val && d >= P + 2 && d <= P + m_n + 1);
      chk("psum_en", psum_en_row_o, ep);
      chk("obuf_wr_en", obuf_wr_en_o, eo);
      if (ew) chk("wbuf_addr", wbuf_rd_addr_o, d - 1);
      if (ei) chk("ibuf_addr", ibuf_rd_addr_o, d - P - 1);
      if (eo) chk("obuf_addr", obuf_wr_addr_o, d - P - 2 - RL);
      if (m_post_rst) begin
        chk("rst_wbuf_addr", wbuf_rd_addr_o, 0);
        chk("rst_ibuf_addr", ibuf_rd_addr_o, 0);
        chk("rst_obuf_addr", obuf_wr_addr_o, 0);
      end
      if (done_o) done_q.push_back(cyc);
      if (obuf_wr_en_o) begin
        wr_q.push_back(cyc);
        wa_q.push_back(int'(obuf_wr_addr_o));
      end
      if (ibuf_rd_en_o) last_ia = ibuf_rd_addr_o;
      m_post_rst = rst;
      if (rst) begin
        m_val = 0;
        m_last_done = -100;
      end else if (m_val && d == dl) begin
        m_val = 0;
        m_last_done = cyc;
      end else if (!m_val && cyc != m_last_done + 1 && start_i && num_rows_i >= 1 && num_rows_i <= 256) begin
        m_val = 1;
        m_s = cyc;
        m_n = num_rows_i;
      end
    end
  end

  task automatic clear_q();
    done_q.delete();
    wr_q.delete();
    wa_q.delete();
  endtask

  initial begin
    repeat (3) tick();
    rst = 0;
    tick();
    // Nominal N=3 run with two ignored start pulses
    clear_q();
    s0 = cyc; start_i = 1; num_rows_i = 3; tick(); start_i = 0;
    repeat (4) tick();
    start_i = 1; tick(); start_i = 0;
    repeat (3) tick();
    start_i = 1; tick(); start_i = 0;
    repeat (15) tick();
    chk("s1_done_count", done_q.size(), 1);
    chk("s1_done_cycle", done_q.size() > 0 ? done_q[0] - s0 : -1, 11);
    chk("s1_write_count", wr_q.size(), 3);
    chk("s1_first_write", wr_q.size() > 0 ? wr_q[0] - s0 : -1, 8);
    chk("s1_last_waddr", wa_q.size() > 2 ? wa_q[2] : -1, 2);
    // Zero row count never starts
    clear_q();
    start_i = 1; num_rows_i = 0;
    repeat (20) tick();
    start_i = 0;
    chk("s2_done_count", done_q.size(), 0);
    chk("s2_write_count", wr_q.size(), 0);
    // Reset mid-operation, then a fresh run offset by 10
    clear_q();
    s0 = cyc; start_i = 1; num_rows_i = 3; tick(); start_i = 0;
    repeat (5) tick();
    rst = 1; tick(); rst = 0;
    chk("s3_busy_after_rst", busy_o, 0);
    repeat (3) tick();
    start_i = 1; tick(); start_i = 0;
    repeat (20) tick();
    chk("s3_done_count", done_q.size(), 1);
    chk("s3_done_cycle", done_q.size() > 0 ? done_q[0] - s0 : -1, 21);
    chk("s3_first_write", wr_q.size() > 0 ? wr_q[0] - s0 : -1, 18);
    // Maximum row count
    clear_q();
    start_i = 1; num_rows_i = 256; tick(); start_i = 0;
    repeat (275) tick();
    chk("s4_write_count", wr_q.size(), 256);
    chk("s4_last_waddr", wa_q.size() > 0 ? wa_q[wa_q.size()-1] : -1, 255);
    chk("s4_last_iaddr", last_ia, 255);
    chk("s4_done_gap", (done_q.size() > 0 && wr_q.size() > 0) ? done_q[0] - wr_q[wr_q.size()-1] : -1, 1);
    // Held start, N=1: back-to-back operations
    clear_q();
    start_i = 1; num_rows_i = 1;
    repeat (40) tick();
    start_i = 0;
    repeat (15) tick();
    chk("s5_done_count", done_q.size(), 4);
    chk("s5_spacing_a", done_q.size() > 1 ? done_q[1] - done_q[0] : -1, 11);
    chk("s5_spacing_b", done_q.size() > 2 ? done_q[2] - done_q[1] : -1, 11);
    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      int r;
      rst = ($urandom_range(0, 99) == 0);
      start_i = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      num_rows_i = (r == 0) ? 9'd0 : (r == 1) ? 9'd300 : RW'($urandom_range(1, 6));
      tick();
    end
    rst = 0; start_i = 0;
    repeat (30) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sa_ctrl.md
Name: sa_ctrl

Overview:
- Sequencer for the PE_SIZE x PE_SIZE systolic array (SA); runs one tile operation per start pulse.
- Operation order: preload weights from the weight buffer, stream N ifmap vectors from the ifmap buffer, skew the per-row psum enables, write N result vectors to the output buffer, then pulse done.
- Owns no datapath; emits only buffer read/write controls and SA enable vectors.

Parameters:
- PE_SIZE, 2, array dimension; width of the enable vectors.
- MAX_ROWS, 256, maximum ifmap vectors per operation.
- ROW_W, $clog2(MAX_ROWS+1), width of row count and addresses.
- RESULT_LAT, 2*PE_SIZE, cycles from ifmap_en_o to the first valid result vector at the SA output.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  start request; sampled only in IDLE.
- num_rows_i  in  ROW_W  ifmap vector count N; latched on accepted start.
- busy_o  out  1  operation in progress.
- done_o  out  1  one-cycle completion pulse.
- wbuf_rd_en_o  out  1  weight buffer read strobe; 1-cycle read latency.
- wbuf_rd_addr_o  out  ROW_W  weight row address.
- ibuf_rd_en_o  out  1  ifmap buffer read strobe; 1-cycle read latency.
- ibuf_rd_addr_o  out  ROW_W  ifmap vector address.
- weight_en_col_o  out  PE_SIZE  weight shift enables to the SA columns.
- ifmap_en_o  out  1  broadcast ifmap enable to the SA.
- psum_en_row_o  out  PE_SIZE  skewed psum enables to the SA rows.
- obuf_wr_en_o  out  1  output buffer write strobe.
- obuf_wr_addr_o  out  ROW_W  output vector address.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters and delay lines cleared. Reset mid-operation aborts immediately; no done_o is generated.
- States and transitions:
  - IDLE -> LOAD_W on start_i with num_rows_i in 1..MAX_ROWS.
  - LOAD_W -> STREAM after PE_SIZE cycles.
  - STREAM -> DRAIN after N cycles.
  - DRAIN -> DONE when the write counter reaches N.
  - DONE -> IDLE after one cycle.
- Timing, with start sampled at cycle 0 and P = PE_SIZE:
  - wbuf_rd_en_o high cycles 1..P; address 0..P-1.
  - weight_en_col_o all-ones cycles 2..P+1 (rd_en delayed 1).
  - ibuf_rd_en_o high cycles P+1..P+N; address 0..N-1.
  - ifmap_en_o high cycles P+2..P+N+1.
  - psum_en_row_o[j] = ifmap_en_o delayed j cycles, j = 0..P-1.
  - obuf_wr_en_o = ifmap_en_o delayed RESULT_LAT cycles; address increments 0..N-1 on each write.
  - done_o high at cycle P+N+2+RESULT_LAT, i.e. the cycle after the last write, in state DONE.
  - busy_o high from cycle 1 through the done_o cycle inclusive.
- Start handling:
  - start_i outside IDLE is ignored, with no queuing.
  - num_rows_i = 0 or > MAX_ROWS: start ignored, busy_o stays 0.
  - start_i held high in IDLE during the DONE->IDLE cycle starts a new operation the cycle after IDLE is re-entered.
- Counters: saturate-free. N <= MAX_ROWS guarantees no address wrap, and addresses never exceed N-1.
- Delay lines: always shift, including in DRAIN, so trailing enables drain naturally. A delay line holds no ones when the FSM is in IDLE.

Decomposition:
- Package sa_pkg holds:
  - state enum: IDLE, LOAD_W, STREAM, DRAIN, DONE.
  - localparam RESULT_LAT.
  - ROW_W derivation.
- Sub-module sa_ctrl_delay: parametric DEPTH shift register with synchronous active-high clear, 1-bit data in, tap vector out.
  - One instance for the psum skew (DEPTH = PE_SIZE).
  - One instance for the write delay (DEPTH = RESULT_LAT).

Test Plan:
- P=2, N=3, start at cycle 0 -> wbuf_rd 1-2 (addr 0,1); weight_en 2-3; ibuf_rd 3-5 (addr 0,1,2); ifmap_en 4-6; psum_en[0] 4-6; psum_en[1] 5-7; obuf_wr 8-10 (addr 0,1,2); done 11; busy 1-11.
- start_i pulsed at cycles 5 and 9 during the N=3 run -> both ignored; exactly one done at 11; no second operation starts.
- num_rows_i=0 with start_i -> busy_o, done_o and all strobes remain 0 for 20 cycles.
- rst asserted at cycle 6 of the N=3 run -> all outputs 0 at cycle 7; no done_o; a fresh start at cycle 10 reproduces scenario 1 timing offset by +10.
- N=MAX_ROWS=256 -> last ibuf addr 255; last obuf addr 255; exactly 256 obuf writes; done one cycle after the last write.
- start_i held high continuously with N=1 -> back-to-back operations with done pulses exactly (P+N+2+RESULT_LAT)+2 = 11 cycles apart.
